// File: rtl/i2c_reg_bank_pkg.sv
// Shared register map and decode types for the i2c register bank.
// Addresses are plain ints so each user can size them to its own address width.
package i2c_reg_bank_pkg;

  localparam int A_ID       = 'h00;
  localparam int A_IRQ_EN   = 'h01;
  localparam int A_STATUS   = 'h02;
  localparam int A_XFER_CNT = 'h03;
  localparam int A_ERR_CNT  = 'h04;
  localparam int A_GP_BASE  = 'h08;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ID,
    SEL_IRQ_EN,
    SEL_STATUS,
    SEL_XFER,
    SEL_ERR,
    SEL_GP
  } reg_sel_e;

endpackage

// File: rtl/i2c_reg_bank_if.sv
// Register-access bus between the i2c slave (master side) and the register bank (slave side).
interface i2c_reg_bank_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          write_en;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] wr_data;
  logic          done;
  logic [DW-1:0] rd_data;

  modport master (output write_en, reg_addr, wr_data, done, input rd_data);
  modport slave  (input write_en, reg_addr, wr_data, done, output rd_data);
endinterface

// File: rtl/i2c_reg_bank_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                       cnt_d = '0;
    else if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/i2c_reg_bank.sv
// Register bank behind the i2c slave: ID, IRQ enable, W1C status, transfer/error
// counters and NUM_GP general-purpose registers exported to fabric.
module i2c_reg_bank
  import i2c_reg_bank_pkg::*;
#(
  parameter int          ADDR_BYTES = 1,
  parameter int          DATA_BYTES = 2,
  parameter int          NUM_GP     = 4,
  parameter logic [15:0] ID_VALUE   = 16'hC2A1
) (
  input  logic                           clk,
  input  logic                           reset,
  i2c_reg_bank_if.slave                  bus,
  input  logic [8*DATA_BYTES-1:0]        hw_event,
  output logic [NUM_GP*8*DATA_BYTES-1:0] gp_out,
  output logic [NUM_GP-1:0]              gp_wr_pulse,
  output logic                           irq
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam logic [DW-1:0] ID_DW = DW'(ID_VALUE);

  reg_sel_e      sel;
  logic [AW-1:0] gp_off;

  logic [DW-1:0] irq_en_q, irq_en_d;
  logic [DW-1:0] status_q, status_d;
  logic [DW-1:0] rd_q, rd_d;
  logic          irq_q;
  logic [NUM_GP-1:0] gp_we, gp_wr_pulse_q;
  logic [DW-1:0] gp_vals [NUM_GP];
  logic [DW-1:0] xfer_cnt, err_cnt;

  logic we_irq_en, we_status, we_xfer, we_err, we_unmapped;

  // One decode serves both reads and writes; GP offset is only meaningful when sel == SEL_GP.
  always_comb begin
    sel    = SEL_NONE;
    gp_off = bus.reg_addr - AW'(A_GP_BASE);
    if      (bus.reg_addr == AW'(A_ID))       sel = SEL_ID;
    else if (bus.reg_addr == AW'(A_IRQ_EN))   sel = SEL_IRQ_EN;
    else if (bus.reg_addr == AW'(A_STATUS))   sel = SEL_STATUS;
    else if (bus.reg_addr == AW'(A_XFER_CNT)) sel = SEL_XFER;
    else if (bus.reg_addr == AW'(A_ERR_CNT))  sel = SEL_ERR;
    else if ((bus.reg_addr >= AW'(A_GP_BASE)) && (gp_off < AW'(NUM_GP))) sel = SEL_GP;
  end

  assign we_irq_en   = bus.write_en && (sel == SEL_IRQ_EN);
  assign we_status   = bus.write_en && (sel == SEL_STATUS);
  assign we_xfer     = bus.write_en && (sel == SEL_XFER);
  assign we_err      = bus.write_en && (sel == SEL_ERR);
  assign we_unmapped = bus.write_en && (sel == SEL_NONE);

  // Set beats clear: hw_event is ORed in after the W1C mask.
  assign irq_en_d = we_irq_en ? bus.wr_data : irq_en_q;
  assign status_d = (status_q & ~(we_status ? bus.wr_data : '0)) | hw_event;

  always_comb begin
    rd_d = '0;
    case (sel)
      SEL_ID:     rd_d = ID_DW;
      SEL_IRQ_EN: rd_d = irq_en_q;
      SEL_STATUS: rd_d = status_q;
      SEL_XFER:   rd_d = xfer_cnt;
      SEL_ERR:    rd_d = err_cnt;
      SEL_GP: begin
        for (int k = 0; k < NUM_GP; k++) begin
          if (gp_off == AW'(k)) rd_d = gp_vals[k];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en_q      <= '0;
      status_q      <= '0;
      rd_q          <= '0;
      irq_q         <= 1'b0;
      gp_wr_pulse_q <= '0;
    end else begin
      irq_en_q      <= irq_en_d;
      status_q      <= status_d;
      rd_q          <= rd_d;
      irq_q         <= |(status_d & irq_en_d);
      gp_wr_pulse_q <= gp_we;
    end
  end

  for (genvar k = 0; k < NUM_GP; k++) begin : g_gp
    logic [DW-1:0] gp_q;

    assign gp_we[k] = bus.write_en && (sel == SEL_GP) && (gp_off == AW'(k));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)        gp_q <= '0;
      else if (gp_we[k]) gp_q <= bus.wr_data;
    end

    assign gp_vals[k]         = gp_q;
    assign gp_out[k*DW +: DW] = gp_q;
  end

  sat_counter #(.W(DW)) u_xfer_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (we_xfer),
    .inc   (bus.done),
    .count (xfer_cnt)
  );

  sat_counter #(.W(DW)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (we_err),
    .inc   (we_unmapped),
    .count (err_cnt)
  );

  assign bus.rd_data = rd_q;
  assign irq         = irq_q;
  assign gp_wr_pulse = gp_wr_pulse_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Directed bench for i2c_reg_bank: register map, W1C/irq, counter saturation,
// unmapped accesses and asynchronous reset.
module tb_i2c_reg_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hw_event;
  logic [63:0] gp_out;
  logic [3:0]  gp_wr_pulse;
  logic        irq;
  logic [15:0] rdv;

  int n_cmp = 0;
  int n_err = 0;

  i2c_reg_bank_if #(.AW(8), .DW(16)) bus ();

  i2c_reg_bank #(
    .ADDR_BYTES (1),
    .DATA_BYTES (2),
    .NUM_GP     (4),
    .ID_VALUE   (16'hC2A1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .hw_event    (hw_event),
    .gp_out      (gp_out),
    .gp_wr_pulse (gp_wr_pulse),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    bus.write_en = 1'b1;
    bus.reg_addr = a;
    bus.wr_data  = d;
    tick();
    bus.write_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [15:0] d);
    bus.reg_addr = a;
    tick();
    d = bus.rd_data;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.write_en = 1'b0;
    bus.reg_addr = 8'h00;
    bus.wr_data  = 16'h0000;
    bus.done     = 1'b0;
    hw_event     = 16'h0000;
    reset        = 1'b0;
    repeat (2) tick();

    // reset state and ID
    chk("rst_rd_data", bus.rd_data, 64'h0);
    chk("rst_irq", irq, 64'h0);
    chk("rst_gp_out", gp_out, 64'h0);
    chk("rst_gp_pulse", gp_wr_pulse, 64'h0);
    reset = 1'b1;
    rd(8'h00, rdv); chk("id", rdv, 64'hC2A1);

    // GP write
    wr(8'h09, 16'h1234);
    chk("gp_pulse_hi", gp_wr_pulse, 64'h2);
    chk("gp_out_wr", gp_out, 64'h0000_0000_1234_0000);
    tick();
    chk("gp_pulse_lo", gp_wr_pulse, 64'h0);
    rd(8'h09, rdv); chk("gp1_rd", rdv, 64'h1234);
    rd(8'h08, rdv); chk("gp0_rd", rdv, 64'h0);

    // status, irq, W1C with set-wins
    hw_event = 16'h0005; tick(); hw_event = 16'h0000;
    chk("irq_masked", irq, 64'h0);
    wr(8'h01, 16'h0004);
    chk("irq_en_assert", irq, 64'h1);
    rd(8'h02, rdv); chk("status_set", rdv, 64'h0005);
    bus.write_en = 1'b1; bus.reg_addr = 8'h02; bus.wr_data = 16'h0004; hw_event = 16'h0004;
    tick();
    bus.write_en = 1'b0; hw_event = 16'h0000;
    chk("irq_set_wins", irq, 64'h1);
    rd(8'h02, rdv); chk("status_set_wins", rdv, 64'h0005);
    wr(8'h02, 16'h0005);
    chk("irq_cleared", irq, 64'h0);
    rd(8'h02, rdv); chk("status_cleared", rdv, 64'h0);
    rd(8'h01, rdv); chk("irq_en_rd", rdv, 64'h0004);

    // transfer counter
    bus.done = 1'b1; repeat (3) tick(); bus.done = 1'b0;
    rd(8'h03, rdv); chk("xfer_3", rdv, 64'h3);
    bus.done = 1'b1; repeat (65534) tick(); bus.done = 1'b0;
    rd(8'h03, rdv); chk("xfer_sat", rdv, 64'hFFFF);
    bus.done = 1'b1; wr(8'h03, 16'h0000); bus.done = 1'b0;
    rd(8'h03, rdv); chk("xfer_clr_wins", rdv, 64'h0);
    bus.done = 1'b1; tick(); bus.done = 1'b0;
    rd(8'h03, rdv); chk("xfer_after_clr", rdv, 64'h1);

    // unmapped writes
    wr(8'h05, 16'hAAAA);
    wr(8'h0C, 16'h5555);
    chk("unmapped_pulse", gp_wr_pulse, 64'h0);
    rd(8'h04, rdv); chk("err_cnt_2", rdv, 64'h2);
    rd(8'h05, rdv); chk("rd_05", rdv, 64'h0);
    rd(8'h0C, rdv); chk("rd_0C", rdv, 64'h0);
    chk("gp_out_kept", gp_out, 64'h0000_0000_1234_0000);
    wr(8'h00, 16'hFFFF);
    rd(8'h00, rdv); chk("id_ro", rdv, 64'hC2A1);
    rd(8'h04, rdv); chk("err_id_mapped", rdv, 64'h2);
    wr(8'h04, 16'h0000);
    rd(8'h04, rdv); chk("err_clr", rdv, 64'h0);

    // asynchronous reset mid-transfer
    hw_event = 16'h0004; tick(); hw_event = 16'h0000;
    chk("irq_pre_rst", irq, 64'h1);
    wr(8'h09, 16'h4321);
    chk("rd_pre_rst", bus.rd_data, 64'h1234);
    chk("pulse_pre_rst", gp_wr_pulse, 64'h2);
    #2 reset = 1'b0;
    #1;
    chk("arst_rd_data", bus.rd_data, 64'h0);
    chk("arst_gp_out", gp_out, 64'h0);
    chk("arst_pulse", gp_wr_pulse, 64'h0);
    chk("arst_irq", irq, 64'h0);
    tick();
    reset = 1'b1;
    rd(8'h09, rdv); chk("gp1_after_rst", rdv, 64'h0);
    rd(8'h01, rdv); chk("irq_en_after_rst", rdv, 64'h0);
    rd(8'h03, rdv); chk("xfer_after_rst", rdv, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
